// File: rtl/rpn_calc.sv
// 16-operation RPN calculator on a register-file stack. Key presses are
// edge-detected against the previous key sample; each fresh press runs one op.
module rpn_calc #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [3:0]       key,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [7:0]       counter
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [7:0]       depth_q, depth_d;
  logic [3:0]       prev_key_q, prev_key_d;

  logic [1:0]       key_sel;
  logic             key_onehot;
  logic             press;
  logic [AW-1:0]    idx_top, idx_next, idx_push;
  logic [WIDTH-1:0] a, b, res;
  logic             has1, has2, not_full, is_bin, is_un;

  always_comb begin
    key_sel    = 2'd0;
    key_onehot = 1'b1;
    case (key)
      4'b0111: key_sel = 2'd3;
      4'b1011: key_sel = 2'd2;
      4'b1101: key_sel = 2'd1;
      4'b1110: key_sel = 2'd0;
      default: key_onehot = 1'b0;
    endcase
  end

  assign press    = (prev_key_q == 4'b1111) && key_onehot;
  assign idx_top  = AW'(depth_q - 8'd1);
  assign idx_next = AW'(depth_q - 8'd2);
  assign idx_push = AW'(depth_q);
  assign has1     = (depth_q >= 8'd1);
  assign has2     = (depth_q >= 8'd2);
  assign not_full = (depth_q < DEPTH_C);
  assign a        = stack_q[idx_top];
  assign b        = stack_q[idx_next];

  // Classify the op: binary ops collapse B,A into B's slot, unary ops rewrite A.
  always_comb begin
    is_bin = 1'b0;
    is_un  = 1'b0;
    res    = '0;
    case ({mode, key_sel})
      4'b0001: begin is_bin = 1'b1; res = b + a; end
      4'b0000: begin is_bin = 1'b1; res = b - a; end
      4'b0111: begin is_bin = 1'b1; res = b * a; end
      4'b0110: begin is_bin = 1'b1; res = b & a; end
      4'b0101: begin is_bin = 1'b1; res = b | a; end
      4'b0100: begin is_bin = 1'b1; res = b ^ a; end
      4'b1001: begin is_bin = 1'b1; res = b << a[3:0]; end
      4'b1000: begin is_bin = 1'b1; res = b >> a[3:0]; end
      4'b1111: begin is_un = 1'b1; res = ~a; end
      4'b1110: begin is_un = 1'b1; res = '0 - a; end
      4'b1100: begin is_un = 1'b1; res = a + 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    stack_d    = stack_q;
    depth_d    = depth_q;
    prev_key_d = key;
    if (press) begin
      if (is_bin) begin
        if (has2) begin
          stack_d[idx_next] = res;
          depth_d           = depth_q - 8'd1;
        end
      end else if (is_un) begin
        if (has1) stack_d[idx_top] = res;
      end else begin
        case ({mode, key_sel})
          4'b0011: if (not_full) begin
            stack_d[idx_push] = val;
            depth_d           = depth_q + 8'd1;
          end
          4'b0010: if (has1) depth_d = depth_q - 8'd1;
          4'b1011: if (has1 && not_full) begin
            stack_d[idx_push] = a;
            depth_d           = depth_q + 8'd1;
          end
          4'b1010: if (has2) begin
            stack_d[idx_top]  = b;
            stack_d[idx_next] = a;
          end
          4'b1101: depth_d = 8'd0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (!rst) begin
      depth_q    <= 8'd0;
      prev_key_q <= 4'b1111;
    end else begin
      depth_q    <= depth_d;
      prev_key_q <= prev_key_d;
    end
  end

  // Entries above the depth pointer are never observed, so no reset is needed.
  always_ff @(posedge clk2) begin
    stack_q <= stack_d;
  end

  assign top     = has1 ? a : '0;
  assign next    = has2 ? b : '0;
  assign counter = depth_q;

endmodule

// File: tb/tb_rpn_calc.sv
// Randomised + directed scoreboard bench for rpn_calc against a queue-based
// stack model.
module tb_rpn_calc;
  localparam logic [3:0] K3 = 4'b0111, K2 = 4'b1011, K1 = 4'b1101, K0 = 4'b1110;
  localparam logic [3:0] IDLE = 4'b1111;
  localparam int DEPTH = 16;

  logic        clk2 = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  key = IDLE;
  logic [15:0] val = 16'd0;
  logic [15:0] top, next;
  logic [7:0]  counter;

  rpn_calc dut (
    .clk2(clk2), .rst(rst), .mode(mode), .key(key), .val(val),
    .top(top), .next(next), .counter(counter)
  );

  always #5 clk2 = ~clk2;

  typedef struct packed {
    logic [15:0] t;
    logic [15:0] n;
    logic [7:0]  c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] stk[$];
  logic [3:0]  m_prev = IDLE;
  int          checks = 0;
  int          passed = 0;

  function automatic int key_index(input logic [3:0] k);
    case (k)
      K3: return 3;
      K2: return 2;
      K1: return 1;
      K0: return 0;
      default: return -1;
    endcase
  endfunction

  // Reference model: the stack is a queue whose back is the top of stack.
  task automatic model_step(input logic r, input logic [1:0] m,
                            input logic [3:0] k, input logic [15:0] v);
    logic [15:0] x, y, z;
    int ki;
    if (!r) begin
      stk.delete();
      m_prev = IDLE;
      return;
    end
    ki = key_index(k);
    if (m_prev == IDLE && ki >= 0) begin
      if (m == 2'd0 && ki == 3) begin
        if (stk.size() < DEPTH) stk.push_back(v);
      end else if (m == 2'd0 && ki == 2) begin
        if (stk.size() >= 1) x = stk.pop_back();
      end else if (m == 2'd2 && ki == 3) begin
        if (stk.size() >= 1 && stk.size() < DEPTH) stk.push_back(stk[$]);
      end else if (m == 2'd2 && ki == 2) begin
        if (stk.size() >= 2) begin
          x = stk.pop_back(); y = stk.pop_back();
          stk.push_back(x); stk.push_back(y);
        end
      end else if (m == 2'd3 && ki == 1) begin
        stk.delete();
      end else if (m == 2'd3) begin
        if (stk.size() >= 1) begin
          x = stk.pop_back();
          if (ki == 3) z = ~x;
          else if (ki == 2) z = 16'd0 - x;
          else z = x + 16'd1;
          stk.push_back(z);
        end
      end else begin
        if (stk.size() >= 2) begin
          x = stk.pop_back();  // A
          y = stk.pop_back();  // B
          z = 16'd0;
          if (m == 2'd0) z = (ki == 1) ? y + x : y - x;
          else if (m == 2'd1) begin
            if (ki == 3) z = 16'((32'(y) * 32'(x)) & 32'hFFFF);
            else if (ki == 2) z = y & x;
            else if (ki == 1) z = y | x;
            else z = y ^ x;
          end else z = (ki == 1) ? (y << x[3:0]) : (y >> x[3:0]);
          stk.push_back(z);
        end
      end
    end
    m_prev = k;
  endtask

  task automatic cyc(input logic r, input logic [1:0] m,
                     input logic [3:0] k, input logic [15:0] v);
    exp_t e;
    @(posedge clk2);
    #2;
    rst = r; mode = m; key = k; val = v;
    model_step(r, m, k, v);
    e.c = 8'(stk.size());
    e.t = (stk.size() >= 1) ? stk[$] : 16'd0;
    e.n = (stk.size() >= 2) ? stk[stk.size()-2] : 16'd0;
    sb.push_back(e);
  endtask

  task automatic press(input logic [1:0] m, input logic [3:0] k, input logic [15:0] v);
    cyc(1'b1, m, k, v);
    $display("op mode=%0d key=%b val=%h -> model depth=%0d", m, k, v, stk.size());
    cyc(1'b1, m, IDLE, v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: the DUT updates every edge, so one expectation is due per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk2);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("top", top, e.t);
        chk("next", next, e.n);
        chk("counter", {8'd0, counter}, {8'd0, e.c});
      end
    end
  end

  initial begin
    logic [3:0] k;
    logic [1:0] m;
    int sel;
    // Reset then idle
    cyc(1'b0, 2'd0, IDLE, 16'd0);
    cyc(1'b0, 2'd0, IDLE, 16'd0);
    cyc(1'b1, 2'd0, IDLE, 16'd0);
    // Push sequence, subtract, pop, empty pop
    press(2'd0, K3, 16'h0005);
    press(2'd0, K3, 16'h0003);
    press(2'd0, K0, 16'h0000);
    press(2'd0, K2, 16'h0000);
    press(2'd0, K2, 16'h0000);
    // Logic / multiply
    press(2'd0, K3, 16'h00F0);
    press(2'd0, K3, 16'h0F0F);
    press(2'd1, K1, 16'h0000);
    press(2'd0, K3, 16'h0010);
    press(2'd1, K3, 16'h0000);
    // Dup, increment wrap, swap
    press(2'd0, K3, 16'h1234);
    press(2'd2, K3, 16'h0000);
    press(2'd0, K3, 16'hFFFF);
    press(2'd3, K0, 16'h0000);
    press(2'd2, K2, 16'h0000);
    // Fill, overflow push, held key, multi-key, clear
    press(2'd3, K1, 16'h0000);
    for (int i = 0; i < DEPTH; i++) press(2'd0, K3, 16'(i * 16'h0101));
    press(2'd0, K3, 16'hBEEF);
    press(2'd0, K2, 16'h0000);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'd0, K3, 16'(16'hA000 + i));
    cyc(1'b1, 2'd0, IDLE, 16'h0000);
    cyc(1'b1, 2'd0, 4'b1001, 16'h0000);
    cyc(1'b1, 2'd0, IDLE, 16'h0000);
    press(2'd3, K1, 16'h0000);
    // Reset coinciding with a press
    press(2'd0, K3, 16'h7777);
    cyc(1'b0, 2'd0, K3, 16'h1111);
    cyc(1'b1, 2'd0, IDLE, 16'h0000);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      m = 2'($urandom_range(0, 3));
      if (sel < 5) k = IDLE;
      else if (sel < 9) begin
        case ($urandom_range(0, 3))
          0: k = K0;
          1: k = K1;
          2: k = K2;
          default: k = K3;
        endcase
        if ($urandom_range(0, 9) < 3) begin m = 2'd0; k = K3; end
        if (m == 2'd3 && k == K1 && $urandom_range(0, 3) != 0) k = K0;
      end else k = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 199) != 0), m, k, 16'($urandom));
    end
    repeat (3) @(posedge clk2);
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
